// File: rtl/iob_sync_req_arb_pkg.sv
// Shared definitions for the iob_sync_req_arb block.
//   - arb_state_e : arbiter FSM state encoding (IDLE=0, GRANT=1)
//   - calc_id_w   : width of the binary grantee index for a given requester count
package iob_sync_req_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Index width; a single requester still needs one bit to carry an index.
    function automatic int calc_id_w(input int n_req);
        if (n_req > 32'sd1) begin
            return $clog2(n_req);
        end else begin
            return 32'sd1;
        end
    endfunction

endpackage

// File: rtl/iob_sync_srst.sv
// N-bit two-flop synchronizer with synchronous active-high reset.
//   clk_i : destination clock
//   rst_i : synchronous active-high reset, clears both flop stages
//   d_i   : asynchronous input levels
//   q_o   : d_i after two clk_i flops
module iob_sync_srst #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two-stage capture of the asynchronous levels.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= {W{1'b0}};
            sync_q <= {W{1'b0}};
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/iob_sync_req_arb.sv
// Round-robin arbiter for one single-user resource shared by N_REQ requesters
// whose request levels are asynchronous to clk_i. A grant is held until done_i
// or until the programmable timeout expires; each transaction then closes with
// a per-requester four-phase acknowledge.
//   clk_i         : clock
//   rst_i         : synchronous active-high reset
//   req_i         : request levels (asynchronous)
//   ack_o         : per-requester acknowledge (four-phase)
//   gnt_o         : one-hot grant
//   gnt_valid_o   : OR of gnt_o
//   gnt_id_o      : binary index of the grantee, holds after release
//   done_i        : resource completion pulse (synchronous)
//   timeout_cyc_i : maximum grant length in cycles, 0 disables the timeout
//   timeout_o     : one-cycle pulse after a forced release
module iob_sync_req_arb
    import iob_sync_req_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int TMO_W = 8,
    parameter int ID_W  = calc_id_w(N_REQ)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] ack_o,
    output logic [N_REQ-1:0] gnt_o,
    output logic             gnt_valid_o,
    output logic [ID_W-1:0]  gnt_id_o,
    input  logic             done_i,
    input  logic [TMO_W-1:0] timeout_cyc_i,
    output logic             timeout_o
);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             tmo_q, tmo_d;

    logic [N_REQ-1:0] req_s;
    logic [N_REQ-1:0] elig_s;
    logic             found_s;
    logic [ID_W-1:0]  win_s;
    logic [ID_W-1:0]  cand_s;
    logic             tmo_hit_s;
    logic             release_s;

    iob_sync_srst #(
        .W (N_REQ)
    ) u_req_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (req_i),
        .q_o   (req_s)
    );

    // A requester already holding an acknowledge must drop its request first.
    assign elig_s = req_s & ~ack_q;

    // Round-robin pick: first eligible index after ptr, wrapping modulo N_REQ.
    always_comb begin
        found_s = 1'b0;
        win_s   = ptr_q;
        cand_s  = {ID_W{1'b0}};
        for (int i = 1; i <= N_REQ; i++) begin
            cand_s = ID_W'((int'(ptr_q) + i) % N_REQ);
            if (!found_s && elig_s[cand_s]) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                win_s   = win_s;
            end
        end
    end

    // Forced release when the grant has lasted timeout_cyc_i cycles.
    assign tmo_hit_s = (timeout_cyc_i != {TMO_W{1'b0}}) &&
                       (cnt_q == (timeout_cyc_i - TMO_W'(1'b1)));

    // FSM next state, grant, pointer and timeout counter.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        tmo_d     = 1'b0;
        release_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d = ST_GRANT;
                    gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_s;
                    id_d    = win_s;
                    ptr_d   = win_s;
                    cnt_d   = {TMO_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (cnt_q != {TMO_W{1'b1}}) begin
                    cnt_d = cnt_q + TMO_W'(1'b1);
                end else begin
                    cnt_d = cnt_q;
                end
                // done_i has priority, so a coincident timeout does not pulse.
                if (done_i) begin
                    state_d   = ST_IDLE;
                    gnt_d     = {N_REQ{1'b0}};
                    release_s = 1'b1;
                end else if (tmo_hit_s) begin
                    state_d   = ST_IDLE;
                    gnt_d     = {N_REQ{1'b0}};
                    release_s = 1'b1;
                    tmo_d     = 1'b1;
                end else begin
                    state_d   = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = {N_REQ{1'b0}};
            end
        endcase
    end

    // Ack set on release wins over the clear, so a dropped request still sees a one-cycle ack.
    always_comb begin
        ack_d   = ack_q & req_s;
        valid_d = |gnt_d;
        if (release_s) begin
            ack_d = ack_d | gnt_q;
        end else begin
            ack_d = ack_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= {N_REQ{1'b0}};
            ack_q   <= {N_REQ{1'b0}};
            id_q    <= {ID_W{1'b0}};
            ptr_q   <= ID_W'(N_REQ - 1);
            cnt_q   <= {TMO_W{1'b0}};
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign ack_o       = ack_q;
    assign gnt_id_o    = id_q;
    assign gnt_valid_o = valid_q;
    assign timeout_o   = tmo_q;

endmodule

// File: tb/tb_iob_sync_req_arb.sv
// Directed testbench for iob_sync_req_arb (N_REQ=4, TMO_W=8).
module tb_iob_sync_req_arb;

    logic       clk_i;
    logic       rst_i;
    logic [3:0] req_i;
    logic [3:0] ack_o;
    logic [3:0] gnt_o;
    logic       gnt_valid_o;
    logic [1:0] gnt_id_o;
    logic       done_i;
    logic [7:0] timeout_cyc_i;
    logic       timeout_o;

    int checks;
    int errors;

    iob_sync_req_arb #(
        .N_REQ (4),
        .TMO_W (8)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .ack_o         (ack_o),
        .gnt_o         (gnt_o),
        .gnt_valid_o   (gnt_valid_o),
        .gnt_id_o      (gnt_id_o),
        .done_i        (done_i),
        .timeout_cyc_i (timeout_cyc_i),
        .timeout_o     (timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req_i = 4'b0000;
        done_i = 1'b0;
        timeout_cyc_i = 8'd0;
        ticks(2);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected %b", gnt_o, 4'b0000); end
        checks++; if (ack_o !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected %b", ack_o, 4'b0000); end
        checks++; if (gnt_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", gnt_valid_o); end
        checks++; if (gnt_id_o !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", gnt_id_o); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout_o); end
        // done_i while idle has no effect
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        tick();
        checks++; if (gnt_o !== 4'b0000 || ack_o !== 4'b0000) begin errors++; $display("FAIL idle_done: got gnt=%b ack=%b expected 0000/0000", gnt_o, ack_o); end
    endtask

    task automatic test_single();
        do_reset();
        req_i = 4'b0100;
        ticks(2);
        checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL single_early: got %b expected 0000", gnt_o); end
        tick();
        checks++; if (gnt_o !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected 0100", gnt_o); end
        checks++; if (gnt_id_o !== 2'd2) begin errors++; $display("FAIL single_id: got %0d expected 2", gnt_id_o); end
        checks++; if (gnt_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", gnt_valid_o); end
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        checks++; if (gnt_o !== 4'b0000 || ack_o !== 4'b0100) begin errors++; $display("FAIL single_done: got gnt=%b ack=%b expected 0000/0100", gnt_o, ack_o); end
        checks++; if (gnt_id_o !== 2'd2 || gnt_valid_o !== 1'b0) begin errors++; $display("FAIL single_hold_id: got id=%0d valid=%b expected 2/0", gnt_id_o, gnt_valid_o); end
        ticks(3);
        checks++; if (gnt_o !== 4'b0000 || ack_o !== 4'b0100) begin errors++; $display("FAIL single_no_regrant: got gnt=%b ack=%b expected 0000/0100", gnt_o, ack_o); end
        req_i = 4'b0000;
        ticks(2);
        checks++; if (ack_o !== 4'b0100) begin errors++; $display("FAIL single_ack_hold: got %b expected 0100", ack_o); end
        tick();
        checks++; if (ack_o !== 4'b0000) begin errors++; $display("FAIL single_ack_clear: got %b expected 0000", ack_o); end
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_gnt;
        int gcount = 0;
        int held = 0;
        int idle = 0;
        int cyc = 0;
        logic prev_valid = 1'b0;
        do_reset();
        req_i = 4'b1111;
        while (cyc < 400 && !(gcount == 5 && !gnt_valid_o)) begin
            tick();
            cyc++;
            if (gnt_valid_o) begin
                if (!prev_valid) begin
                    if (gcount < 5) begin
                        exp_gnt = 4'b0001 << exp_order[gcount];
                        checks++; if (gnt_id_o !== 2'(exp_order[gcount]) || gnt_o !== exp_gnt) begin errors++; $display("FAIL rr_order[%0d]: got id=%0d gnt=%b expected id=%0d gnt=%b", gcount, gnt_id_o, gnt_o, exp_order[gcount], exp_gnt); end
                        if (gcount > 0) begin
                            checks++; if (idle !== 1) begin errors++; $display("FAIL rr_gap[%0d]: got %0d idle cycles expected 1", gcount, idle); end
                        end
                    end
                    gcount++;
                    held = 0;
                    idle = 0;
                end
                held++;
                done_i = (held == 5);
            end else begin
                done_i = 1'b0;
                idle++;
            end
            prev_valid = gnt_valid_o;
            // four-phase requesters: drop on ack, re-raise once ack is gone
            for (int k = 0; k < 4; k++) begin
                if (ack_o[k] && req_i[k]) req_i[k] = 1'b0;
                else if (!ack_o[k] && !req_i[k]) req_i[k] = 1'b1;
            end
        end
        done_i = 1'b0;
        checks++; if (gcount !== 5) begin errors++; $display("FAIL rr_count: got %0d grants expected 5 within budget", gcount); end
    endtask

    task automatic test_timeout();
        int bad = 0;
        do_reset();
        timeout_cyc_i = 8'd8;
        req_i = 4'b0010;
        ticks(3);
        for (int i = 0; i < 8; i++) begin
            if (gnt_o !== 4'b0010 || timeout_o !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL tmo_hold: got %0d bad cycles expected 0", bad); end
        checks++; if (gnt_o !== 4'b0000 || timeout_o !== 1'b1 || ack_o !== 4'b0010) begin errors++; $display("FAIL tmo_release: got gnt=%b tmo=%b ack=%b expected 0000/1/0010", gnt_o, timeout_o, ack_o); end
        tick();
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL tmo_pulse: got %b expected 0", timeout_o); end
        // timeout disabled: grant never releases
        timeout_cyc_i = 8'd0;
        req_i = 4'b0000;
        ticks(3);
        req_i = 4'b0010;
        ticks(3);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (gnt_o !== 4'b0010 || timeout_o !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL tmo_disabled: got %0d bad cycles expected 0", bad); end
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        checks++; if (gnt_o !== 4'b0000 || ack_o !== 4'b0010) begin errors++; $display("FAIL tmo_disabled_done: got gnt=%b ack=%b expected 0000/0010", gnt_o, ack_o); end
    endtask

    task automatic test_done_timeout_collide();
        do_reset();
        timeout_cyc_i = 8'd8;
        req_i = 4'b1000;
        ticks(3);
        checks++; if (gnt_o !== 4'b1000 || gnt_id_o !== 2'd3) begin errors++; $display("FAIL col_gnt: got gnt=%b id=%0d expected 1000/3", gnt_o, gnt_id_o); end
        ticks(7);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        checks++; if (gnt_o !== 4'b0000 || ack_o !== 4'b1000 || timeout_o !== 1'b0) begin errors++; $display("FAIL col_release: got gnt=%b ack=%b tmo=%b expected 0000/1000/0", gnt_o, ack_o, timeout_o); end
        tick();
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL col_no_pulse: got %b expected 0", timeout_o); end
    endtask

    task automatic test_drop_during_grant();
        int bad = 0;
        do_reset();
        req_i = 4'b0001;
        ticks(3);
        checks++; if (gnt_o !== 4'b0001 || gnt_id_o !== 2'd0) begin errors++; $display("FAIL drop_gnt: got gnt=%b id=%0d expected 0001/0", gnt_o, gnt_id_o); end
        req_i = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (gnt_o !== 4'b0001) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL drop_persist: got %0d bad cycles expected 0", bad); end
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        checks++; if (gnt_o !== 4'b0000 || ack_o !== 4'b0001) begin errors++; $display("FAIL drop_ack_rise: got gnt=%b ack=%b expected 0000/0001", gnt_o, ack_o); end
        tick();
        checks++; if (ack_o !== 4'b0000 || gnt_o !== 4'b0000) begin errors++; $display("FAIL drop_ack_fall: got ack=%b gnt=%b expected 0000/0000", ack_o, gnt_o); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req_i = 4'b0100;
        ticks(3);
        checks++; if (gnt_o !== 4'b0100) begin errors++; $display("FAIL rst_pre_gnt: got %b expected 0100", gnt_o); end
        req_i = 4'b1111;
        rst_i = 1'b1;
        tick();
        checks++; if (gnt_o !== 4'b0000 || ack_o !== 4'b0000 || gnt_valid_o !== 1'b0 || gnt_id_o !== 2'd0 || timeout_o !== 1'b0) begin errors++; $display("FAIL rst_mid: got gnt=%b ack=%b valid=%b id=%0d tmo=%b expected all 0", gnt_o, ack_o, gnt_valid_o, gnt_id_o, timeout_o); end
        rst_i = 1'b0;
        ticks(2);
        checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL rst_resync: got %b expected 0000", gnt_o); end
        tick();
        checks++; if (gnt_o !== 4'b0001 || gnt_id_o !== 2'd0) begin errors++; $display("FAIL rst_prio: got gnt=%b id=%0d expected 0001/0", gnt_o, gnt_id_o); end
        checks++; if (ack_o !== 4'b0000) begin errors++; $display("FAIL rst_no_ack: got %b expected 0000", ack_o); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_i = 1'b1;
        req_i = 4'b0000;
        done_i = 1'b0;
        timeout_cyc_i = 8'd0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_done_timeout_collide();
        test_drop_during_grant();
        test_reset_mid_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_sync_req_arb.md
# iob_sync_req_arb

Round-robin arbiter that shares one single-user resource between `N_REQ` requesters whose request lines come from another clock domain. Each request is passed through a two-flop synchronizer. The arbiter then issues a one-hot grant and holds it until the resource reports completion or a programmable timeout expires. Each transaction closes with a per-requester four-phase acknowledge, so requesters can use a plain level handshake across the domain boundary.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..16.
- `TMO_W`, 8: width of the timeout counter and of `timeout_cyc_i`.
- `ID_W`, `$clog2(N_REQ)`: width of `gnt_id_o`. Derived; not overridden.

Ports:
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset. Synchronous, active-high.
- `req_i`, input, `N_REQ`: request levels, asynchronous to `clk_i`.
- `ack_o`, output, `N_REQ`: per-requester acknowledge, four-phase.
- `gnt_o`, output, `N_REQ`: one-hot grant to the resource mux.
- `gnt_valid_o`, output, 1: OR of `gnt_o`.
- `gnt_id_o`, output, `ID_W`: binary index of the current grantee. Holds the last value when no grant is active.
- `done_i`, input, 1: resource completion pulse. Synchronous to `clk_i`.
- `timeout_cyc_i`, input, `TMO_W`: maximum grant length in cycles. 0 disables the timeout.
- `timeout_o`, output, 1: one-cycle pulse when a grant is force-released.

## Operation
- **Synchronizer:** `req_s[k]` is `req_i[k]` after 2 flops. All arbitration uses `req_s` only.
- **Eligibility:** `elig[k] = req_s[k] & ~ack_o[k]`.
- **FSM states:** IDLE, GRANT.
- **IDLE → GRANT:** taken when `elig != 0`.
  - Winner is the first eligible index searched from `ptr+1` upward, wrapping modulo `N_REQ`.
  - Winner is registered into `gnt_o` and `gnt_id_o`; `ptr` is set to the winner.
  - The timeout counter is cleared.
- **In GRANT:** the counter increments every cycle and saturates at all-ones.
- **GRANT → IDLE on completion:** taken when `done_i=1`.
  - `gnt_o` is cleared.
  - `ack_o[gnt_id_o]` is set.
- **GRANT → IDLE on timeout:** taken when `done_i=0`, `timeout_cyc_i != 0` and `cnt == timeout_cyc_i-1`.
  - Same actions as completion.
  - In addition `timeout_o` pulses for 1 cycle.
- **Simultaneous done and timeout:** `done_i` wins; no `timeout_o` pulse.
- **Acknowledge clear:** `ack_o[k]` clears on the first cycle with `req_s[k]=0`. This is independent of FSM state and of other requesters.
- **Request dropped during grant:** the grant is not aborted. It runs to done or timeout. `ack_o` then rises for exactly 1 cycle, because `req_s` is already low.
- **`done_i` in IDLE:** ignored.
- **Changing `timeout_cyc_i` during GRANT:** takes effect immediately.
- **Grant gap:** there is always at least 1 IDLE cycle between consecutive grants.
- **Reset:** all outputs return to 0, sync flops clear, state returns to IDLE. `ptr` resets to `N_REQ-1`, so index 0 has highest priority after reset. A reset during GRANT drops `gnt_o` on that edge and no `ack_o` is issued.

## Timing
- **Reset values:** `ack_o=0`, `gnt_o=0`, `gnt_valid_o=0`, `gnt_id_o=0`, `timeout_o=0`.
- **Request to grant:**
  - `req_i` is stable before edge E0.
  - `req_s` is high after E1.
  - `gnt_o` is high after E2, i.e. 3 edges of latency.
- **Grant to acknowledge:** `done_i` high at edge E clears `gnt_o` and sets `ack_o` after E.
  - The next grant, to another requester, can appear after E+1.
- **Timeout:** with `timeout_cyc_i=T` and no done, `gnt_o` stays high for exactly T cycles. `timeout_o` is high during the cycle after release.
- **Acknowledge release:** `req_i` falling before edge F clears `ack_o` after F+2.
- **Registering:** all outputs are registered. No combinational path exists from any input to any output.

## Structure
- **Shared package:** FSM state encoding (IDLE=0, GRANT=1) and the `ID_W` derivation helper go in the block's shared package.
- **Sub-module `iob_sync_srst`:** an N-bit two-flop synchronizer with synchronous active-high reset `rst_i`, instantiated once with width `N_REQ`. It is needed because `iob_sync` resets asynchronously.
- **Top-level contents:** the round-robin pick stays combinational inside the top level. Also in the top level are the FSM, `ptr`, timeout counter and ack registers.

## Test plan
- **Single request:** `req_i=4'b0100` → `gnt_o=4'b0100` and `gnt_id_o=2` 3 edges later. `done_i` pulse → `ack_o[2]=1`. Drop `req_i[2]` → `ack_o[2]=0` 2 edges later.
- **Round-robin:** all 4 held high, `done_i` 5 cycles after each grant → grant order 0,1,2,3,0. Exactly 1 IDLE cycle between grants.
- **Timeout:** `timeout_cyc_i=8`, `req_i[1]` high, `done_i` never asserted → `gnt_o[1]` high for 8 cycles, then `timeout_o` pulse and `ack_o[1]=1`. With `timeout_cyc_i=0` the grant never releases.
- **Simultaneous done and timeout:** `done_i` at cycle 7 with `timeout_cyc_i=8` → release with `timeout_o=0`.
- **Request dropped during grant:** grantee deasserts `req_i` mid-grant → grant persists until `done_i`, then `ack_o` high for exactly 1 cycle.
- **Reset mid-grant:** `rst_i` during GRANT → all outputs 0 on the next edge. Afterwards, with all requests held high, the next grant goes to index 0.
